bounce_counter: RTL and testbench
=================================

Name: bounce_counter

Overview:
- Parametrised up/down "bounce" counter: moves between LO and HI and reverses direction at each bound.
- Steps on either every clk_1 cycle (fast rate) or a prescaled strobe (slow rate).
- Single clock domain: no derived or muxed clocks. Rate selection is by clock-enable only.
- Feeds display/LED logic via count, mode and step/bounce strobes.

Parameters:
- WIDTH, 4: counter width in bits.
- DIV, 50: slow-rate prescale ratio; one step strobe per DIV clk_1 cycles. Legal range DIV >= 2.
- LO, 0: lower bound. Requires 0 <= LO < HI.
- HI, 2**WIDTH-1: upper bound. Requires HI <= 2**WIDTH-1.

Ports:
- clk_1  in  1  system clock; all state is on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- fast  in  1  rate select: 1 = step every cycle, 0 = step on prescaler strobe.
- en  in  1  step enable; 0 freezes count and mode (prescaler keeps running).
- auto_dir  in  1  1 = direction from mode; 0 = direction from dir_btn.
- dir_btn  in  1  manual direction: 0 = up, 1 = down.
- load  in  1  synchronous load request.
- load_val  in  WIDTH  load value.
- count  out  WIDTH  counter value.
- mode  out  1  bounce state: 0 = UP, 1 = DOWN.
- step  out  1  one-cycle pulse on every accepted step cycle.
- bounce  out  1  one-cycle pulse on a cycle where mode reverses.

Behaviour:
- Reset (async assert, rising-edge-synchronous release):
  - count=LO, mode=UP(0), step=0, bounce=0, prescaler=0.
- Prescaler:
  - Counts 0..DIV-1 free-running, wraps to 0.
  - slow_stb=1 in the cycle the prescaler equals DIV-1.
  - Cleared only by rst; not cleared by fast changes or load.
- Step qualification: go = en & (fast | slow_stb) & ~load.
  - fast switching mid-run takes effect next cycle. No glitch, no lost or double prescaler state.
- Priority per cycle: rst > load > step > hold.
- Load:
  - count <= load_val clamped to [LO,HI].
  - mode <= UP, unless the clamped value == HI, in which case mode <= DOWN.
  - step=0, bounce=0.
- Step rules when go=1, registered outputs (count/mode update one cycle after go):
  - Direction d = auto_dir ? mode : dir_btn (0 = up, 1 = down).
  - Bound check happens before the move: mode=UP and count==HI → mode<=DOWN, count holds, bounce=1 (one-step dwell at bound).
  - Mirror case: mode=DOWN and count==LO → mode<=UP, count holds, bounce=1.
  - Otherwise: d=up → count+1; d=down → count-1.
    - Clamp: if the result would leave [LO,HI], count holds and bounce=0.
    - No modular wrap ever occurs.
  - step=1 on every go cycle, including dwell and clamped-hold cycles.
- go=0: count, mode hold; step=0, bounce=0.
- en=0: slow strobes are lost, not queued.
- Arithmetic: WIDTH-bit unsigned. Bound compares use full width; no overflow possible given clamping.
- Reset mid-step: async clear wins immediately; first step after release is on the first qualified cycle.

Decomposition:
- Shared package holds:
  - Direction encoding constants DIR_UP=1'b0, DIR_DOWN=1'b1.
  - Parameter-legality checks (elaboration-time assertions on DIV, LO, HI).
- Natural sub-module: tick_prescaler.
  - Parameter DIV; ports clk_1, rst, out stb.
  - Reused by other rate-selected blocks in the codebase.

Test Plan:
- Fast bounce (WIDTH=4, DIV=4, fast=1, auto_dir=1, en=1, from reset):
  - count 0,1,...,15, dwell 15 with bounce=1 and mode→1, then 14,...,0, dwell 0 with bounce=1 and mode→0.
  - Full period is 32 steps.
- Slow rate (fast=0, DIV=4):
  - step pulses exactly every 4th cycle; count advances 0→1→2 at cycles 4, 8.
  - Toggling fast=1 at cycle 9 gives a step every cycle from cycle 10.
- Manual clamp (auto_dir=0, count=LO=0, mode=UP, dir_btn=1, fast=1):
  - count stays 0, step=1, bounce=0.
  - dir_btn=0 then counts up.
- Load (load_val=20, WIDTH=5, HI=12):
  - count=12, mode=DOWN.
  - Next fast step gives count=11, bounce=0.
  - load asserted together with go: load wins and no step pulse.
- Enable/reset (en=0 for 10 cycles mid-count at 7):
  - count stays 7.
  - rst pulsed asynchronously between edges: count=0, mode=0 immediately; prescaler restarts at 0.

Source files
------------

// File: rtl/bounce_counter_pkg.sv
// Shared definitions for the bounce counter and its prescaler.
// Holds direction encodings, the mode type and parameter legality helpers.
package bounce_counter_pkg;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    typedef enum logic {
        MODE_UP   = 1'b0,
        MODE_DOWN = 1'b1
    } mode_e;

    function automatic bit div_ok(int div);
        return div >= 2;
    endfunction

    function automatic bit bounds_ok(int width, int lo, int hi);
        longint max_v;
        max_v = (longint'(1) << width) - 1;
        return (lo >= 0) && (lo < hi) && (longint'(hi) <= max_v);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running 0..DIV-1 counter producing a one-cycle strobe at DIV-1.
// Ports: clk_1, rst (async, active-high) in; stb out.
module tick_prescaler
    import bounce_counter_pkg::*;
#(
    parameter int DIV = 50
) (
    input  logic clk_1,
    input  logic rst,
    output logic stb
);

    if (!div_ok(DIV)) begin : g_div_chk
        $error("tick_prescaler: DIV must be >= 2");
    end

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk_1 or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign stb = (cnt == LAST);

endmodule

// File: rtl/bounce_counter.sv
// Up/down counter that bounces between LO and HI, one step per fast cycle or
// per prescaler strobe. Ports: clk_1, rst, fast, en, auto_dir, dir_btn, load,
// load_val in; count, mode, step, bounce out (all registered).
module bounce_counter
    import bounce_counter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DIV   = 50,
    parameter int LO    = 0,
    parameter int HI    = 2**WIDTH - 1
) (
    input  logic             clk_1,
    input  logic             rst,
    input  logic             fast,
    input  logic             en,
    input  logic             auto_dir,
    input  logic             dir_btn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             mode,
    output logic             step,
    output logic             bounce
);

    if (!bounds_ok(WIDTH, LO, HI)) begin : g_bound_chk
        $error("bounce_counter: need 0 <= LO < HI <= 2**WIDTH-1");
    end

    localparam logic [WIDTH-1:0] LO_V = WIDTH'(LO);
    localparam logic [WIDTH-1:0] HI_V = WIDTH'(HI);

    logic             slow_stb;
    logic             go;
    logic             dir;
    logic [WIDTH-1:0] ld_clamp;

    mode_e            mode_q;
    mode_e            mode_d;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             step_q;
    logic             step_d;
    logic             bounce_q;
    logic             bounce_d;

    tick_prescaler #(
        .DIV(DIV)
    ) u_presc (
        .clk_1(clk_1),
        .rst  (rst),
        .stb  (slow_stb)
    );

    assign go  = en & (fast | slow_stb) & ~load;
    assign dir = auto_dir ? logic'(mode_q) : dir_btn;

    // <= / >= keep the compares non-constant when LO=0 or HI is max
    assign ld_clamp = (load_val <= LO_V) ? LO_V :
                      (load_val >= HI_V) ? HI_V : load_val;

    always_ff @(posedge clk_1 or posedge rst) begin
        if (rst) begin
            count_q  <= LO_V;
            mode_q   <= MODE_UP;
            step_q   <= 1'b0;
            bounce_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            mode_q   <= mode_d;
            step_q   <= step_d;
            bounce_q <= bounce_d;
        end
    end

    always_comb begin
        count_d  = count_q;
        mode_d   = mode_q;
        step_d   = 1'b0;
        bounce_d = 1'b0;
        unique case (1'b1)
            load: begin
                count_d = ld_clamp;
                mode_d  = (ld_clamp == HI_V) ? MODE_DOWN : MODE_UP;
            end
            go: begin
                step_d = 1'b1;
                // Reversal dwells one step at the bound before moving
                if (mode_q == MODE_UP && count_q == HI_V) begin
                    mode_d   = MODE_DOWN;
                    bounce_d = 1'b1;
                end else if (mode_q == MODE_DOWN && count_q == LO_V) begin
                    mode_d   = MODE_UP;
                    bounce_d = 1'b1;
                end else if (dir == DIR_UP) begin
                    if (count_q != HI_V) count_d = count_q + WIDTH'(1);
                end else begin
                    if (count_q != LO_V) count_d = count_q - WIDTH'(1);
                end
            end
            default: ;
        endcase
    end

    assign count  = count_q;
    assign mode   = logic'(mode_q);
    assign step   = step_q;
    assign bounce = bounce_q;

endmodule

// File: tb/tb_bounce_counter.sv
// Directed self-checking bench for bounce_counter.
// Instance a: WIDTH=4 DIV=4 full range; instance b: WIDTH=5 DIV=4 HI=12.
module tb_bounce_counter;

    logic       clk_1 = 1'b0;
    logic       rst;
    logic       fast;
    logic       en;
    logic       auto_dir;
    logic       dir_btn;
    logic       load;
    logic [3:0] load_val_a;
    logic [4:0] load_val_b;
    logic [3:0] count_a;
    logic       mode_a;
    logic       step_a;
    logic       bounce_a;
    logic [4:0] count_b;
    logic       mode_b;
    logic       step_b;
    logic       bounce_b;

    int errors = 0;
    int checks = 0;

    always #5 clk_1 = ~clk_1;

    bounce_counter #(
        .WIDTH(4), .DIV(4), .LO(0), .HI(15)
    ) u_a (
        .clk_1   (clk_1),
        .rst     (rst),
        .fast    (fast),
        .en      (en),
        .auto_dir(auto_dir),
        .dir_btn (dir_btn),
        .load    (load),
        .load_val(load_val_a),
        .count   (count_a),
        .mode    (mode_a),
        .step    (step_a),
        .bounce  (bounce_a)
    );

    bounce_counter #(
        .WIDTH(5), .DIV(4), .LO(0), .HI(12)
    ) u_b (
        .clk_1   (clk_1),
        .rst     (rst),
        .fast    (fast),
        .en      (en),
        .auto_dir(auto_dir),
        .dir_btn (dir_btn),
        .load    (load),
        .load_val(load_val_b),
        .count   (count_b),
        .mode    (mode_b),
        .step    (step_b),
        .bounce  (bounce_b)
    );

    task automatic tick();
        @(posedge clk_1);
        #1;
    endtask

    // Asynchronous pulse placed between clock edges
    task automatic pulse_rst();
        #2 rst = 1'b1;
        #1 rst = 1'b0;
    endtask

    task automatic idle_inputs();
        fast = 1'b0; en = 1'b0; auto_dir = 1'b1; dir_btn = 1'b0;
        load = 1'b0; load_val_a = '0; load_val_b = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        checks++;
        if ({count_a, mode_a, step_a, bounce_a} !== 7'b0) begin
            errors++;
            $display("FAIL reset_a: got c=%0d m=%0b s=%0b b=%0b want 0 0 0 0",
                     count_a, mode_a, step_a, bounce_a);
        end
        checks++;
        if ({count_b, mode_b, step_b, bounce_b} !== 8'b0) begin
            errors++;
            $display("FAIL reset_b: got c=%0d m=%0b s=%0b b=%0b want 0 0 0 0",
                     count_b, mode_b, step_b, bounce_b);
        end
        rst = 1'b0;
    endtask

    task automatic test_fast_bounce();
        int ec;
        logic em, eb;
        pulse_rst();
        fast = 1'b1; en = 1'b1; auto_dir = 1'b1;
        for (int k = 1; k <= 33; k++) begin
            tick();
            if (k <= 15)      ec = k;
            else if (k == 16) ec = 15;
            else if (k <= 31) ec = 31 - k;
            else if (k == 32) ec = 0;
            else              ec = 1;
            em = (k >= 16 && k <= 31);
            eb = (k == 16 || k == 32);
            checks++;
            if (count_a !== 4'(ec) || mode_a !== em ||
                bounce_a !== eb || step_a !== 1'b1) begin
                errors++;
                $display("FAIL fast_bounce k=%0d: got c=%0d m=%0b b=%0b s=%0b want c=%0d m=%0b b=%0b s=1",
                         k, count_a, mode_a, bounce_a, step_a, ec, em, eb);
            end
        end
        idle_inputs();
    endtask

    task automatic test_slow_rate();
        logic es;
        pulse_rst();
        fast = 1'b0; en = 1'b1; auto_dir = 1'b1;
        for (int n = 1; n <= 9; n++) begin
            tick();
            es = (n % 4 == 0);
            checks++;
            if (step_a !== es || count_a !== 4'(n / 4)) begin
                errors++;
                $display("FAIL slow n=%0d: got s=%0b c=%0d want s=%0b c=%0d",
                         n, step_a, count_a, es, n / 4);
            end
        end
        fast = 1'b1;
        for (int n = 10; n <= 12; n++) begin
            tick();
            checks++;
            if (step_a !== 1'b1 || count_a !== 4'(n - 7)) begin
                errors++;
                $display("FAIL slow_to_fast n=%0d: got s=%0b c=%0d want s=1 c=%0d",
                         n, step_a, count_a, n - 7);
            end
        end
        idle_inputs();
    endtask

    task automatic test_manual_clamp();
        pulse_rst();
        fast = 1'b1; en = 1'b1; auto_dir = 1'b0; dir_btn = 1'b1;
        for (int n = 0; n < 2; n++) begin
            tick();
            checks++;
            if (count_a !== 4'd0 || step_a !== 1'b1 ||
                bounce_a !== 1'b0 || mode_a !== 1'b0) begin
                errors++;
                $display("FAIL clamp_lo: got c=%0d s=%0b b=%0b m=%0b want 0 1 0 0",
                         count_a, step_a, bounce_a, mode_a);
            end
        end
        dir_btn = 1'b0;
        for (int n = 1; n <= 2; n++) begin
            tick();
            checks++;
            if (count_a !== 4'(n)) begin
                errors++;
                $display("FAIL manual_up: got c=%0d want %0d", count_a, n);
            end
        end
        idle_inputs();
    endtask

    task automatic test_load();
        pulse_rst();
        load = 1'b1; load_val_a = 4'd9; load_val_b = 5'd20;
        tick();
        checks++;
        if (count_b !== 5'd12 || mode_b !== 1'b1 ||
            step_b !== 1'b0 || bounce_b !== 1'b0) begin
            errors++;
            $display("FAIL load_clamp_b: got c=%0d m=%0b s=%0b b=%0b want 12 1 0 0",
                     count_b, mode_b, step_b, bounce_b);
        end
        checks++;
        if (count_a !== 4'd9 || mode_a !== 1'b0) begin
            errors++;
            $display("FAIL load_a: got c=%0d m=%0b want 9 0", count_a, mode_a);
        end
        load = 1'b0; fast = 1'b1; en = 1'b1; auto_dir = 1'b1;
        tick();
        checks++;
        if (count_b !== 5'd11 || bounce_b !== 1'b0 ||
            step_b !== 1'b1 || mode_b !== 1'b1) begin
            errors++;
            $display("FAIL load_then_step: got c=%0d b=%0b s=%0b m=%0b want 11 0 1 1",
                     count_b, bounce_b, step_b, mode_b);
        end
        load = 1'b1; load_val_b = 5'd5; load_val_a = 4'd15;
        tick();
        checks++;
        if (count_b !== 5'd5 || mode_b !== 1'b0 || step_b !== 1'b0) begin
            errors++;
            $display("FAIL load_wins_b: got c=%0d m=%0b s=%0b want 5 0 0",
                     count_b, mode_b, step_b);
        end
        checks++;
        if (count_a !== 4'd15 || mode_a !== 1'b1 || step_a !== 1'b0) begin
            errors++;
            $display("FAIL load_hi_a: got c=%0d m=%0b s=%0b want 15 1 0",
                     count_a, mode_a, step_a);
        end
        idle_inputs();
    endtask

    task automatic test_enable_reset();
        logic es;
        pulse_rst();
        fast = 1'b1; en = 1'b1; auto_dir = 1'b1;
        repeat (7) tick();
        checks++;
        if (count_a !== 4'd7) begin
            errors++;
            $display("FAIL run_to_7: got c=%0d want 7", count_a);
        end
        en = 1'b0;
        fast = 1'b0;
        for (int n = 0; n < 10; n++) begin
            tick();
            checks++;
            if (count_a !== 4'd7 || step_a !== 1'b0) begin
                errors++;
                $display("FAIL en_hold n=%0d: got c=%0d s=%0b want 7 0",
                         n, count_a, step_a);
            end
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (count_a !== 4'd0 || mode_a !== 1'b0) begin
            errors++;
            $display("FAIL async_rst: got c=%0d m=%0b want 0 0", count_a, mode_a);
        end
        rst = 1'b0;
        en = 1'b1;
        fast = 1'b0;
        for (int n = 1; n <= 4; n++) begin
            tick();
            es = (n == 4);
            checks++;
            if (step_a !== es || count_a !== 4'(n / 4)) begin
                errors++;
                $display("FAIL presc_restart n=%0d: got s=%0b c=%0d want s=%0b c=%0d",
                         n, step_a, count_a, es, n / 4);
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_fast_bounce();
        test_slow_rate();
        test_manual_clamp();
        test_load();
        test_enable_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
